des_stream_ctrl: RTL and testbench
==================================

// Module: des_stream_ctrl
// PURPOSE
//  Upstream feeder/collector for the iterative 16-round DES codec. Packs 32-bit bus words into 64-bit
//  blocks and buffers them in a FIFO. Launches one codec operation at a time with a 1-cycle start pulse
//  and holds the key stable while the codec computes. Captures the codec result and presents it on a
//  64-bit valid/ready output. Sits between the APB-side data registers and codec_des.
// PARAMETERS
//  FIFO_DEPTH  4   input block FIFO entries (power of 2, >=2)
//  TIMEOUT     32  max cycles in WAIT before error abort (must exceed codec latency of 17)
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous active-high reset
//  s_valid      in   1   input word valid
//  s_ready      out  1   input word accepted when s_valid&&s_ready
//  s_data       in   32  input word; 1st word of block = bits [0:31], 2nd = [32:63] (MSB-first)
//  key_we       in   1   key write strobe
//  key_i        in   64  new key value
//  m_valid      out  1   result block valid
//  m_ready      in   1   result consumed when m_valid&&m_ready
//  m_data       out  64  result block
//  des_valid_o  out  1   start pulse to codec valid_i
//  des_data_o   out  64  block to codec data_i
//  des_key_o    out  64  key to codec key (registered)
//  des_valid_i  in   1   codec valid_o
//  des_data_i   in   64  codec data_o
//  blk_cnt      out  16  completed-block counter
//  err          out  1   sticky timeout error
// BEHAVIOUR
//  Reset: all outputs 0, s_ready 0 then 1 from the first post-reset cycle, FSM=IDLE, FIFO empty,
//   half-word flag cleared, key register 0, key_pending 0.
//  Packer: 1st accepted word goes to a hold register. 2nd word plus the hold register is pushed as one
//   64-bit block. s_ready = !fifo_full. A word arriving while the FIFO is full stalls. A half-packed
//   word is kept indefinitely.
//  FIFO: write on 2nd-word accept, read on LAUNCH. Simultaneous push and pop when full is allowed
//   (the pop frees the slot). Pointers wrap modulo FIFO_DEPTH and use an extra wrap bit for full/empty.
//  Key: key_we in IDLE loads the key register next cycle. key_we in LAUNCH/WAIT/OUT stores key_i in a
//   pending register and sets key_pending. The pending key is applied on return to IDLE. A pending load
//   takes effect before the next LAUNCH. The last key_we wins. des_key_o never changes outside IDLE.
//  FSM:
//   IDLE: if key_pending, apply the key and stay 1 cycle. Otherwise, if FIFO non-empty, go to LAUNCH.
//   LAUNCH: des_valid_o=1 for exactly 1 cycle, des_data_o=FIFO head, pop. Next state WAIT, tmo_cnt=0.
//   WAIT: tmo_cnt++. On des_valid_i: capture des_data_i into m_data, m_valid<=1, blk_cnt++, go to OUT.
//    If tmo_cnt==TIMEOUT-1 with no des_valid_i: err<=1, drop the block, go to IDLE.
//   OUT: hold m_valid/m_data stable until m_ready, then m_valid<=0 and go to IDLE.
//  Latency: LAUNCH cycle T -> des_valid_i at T+17 -> m_valid at T+18.
//   Minimum block period is 20 cycles with m_ready tied high.
//  des_valid_i outside WAIT is ignored. des_data_o holds its last value outside LAUNCH.
//  blk_cnt wraps from 0xFFFF to 0. err clears only on rst.
//  Reset mid-operation: everything returns to reset values and any in-flight codec result is ignored.
//   The codec reset (rst_n) is driven as ~rst by the parent.
// TESTING
//  1 Words 0x01234567, 0x89ABCDEF with key 0x133457799BBCDFF1 (ENCRYPT codec)
//    -> m_data=0x85E813540F0AB405, des_valid_o pulse width 1, m_valid 18 cycles after the pulse.
//  2 Push FIFO_DEPTH+1 blocks (m_ready=0) -> s_ready drops when the FIFO is full, and the stall
//    releases after the first OUT handshake. All results come out in order and blk_cnt matches.
//  3 key_we with a new key during WAIT -> des_key_o unchanged until IDLE. The next block uses the new
//    key, and the current result uses the old key.
//  4 Hold des_valid_i=0 with codec stubbed -> err=1 after TIMEOUT cycles in WAIT, FSM back in IDLE,
//    the next block processes normally, and err stays 1.
//  5 Assert rst during WAIT and during half-packed state -> all outputs 0, FIFO empty, and a late
//    des_valid_i produces no m_valid.

Source files
------------

// File: rtl/des_stream_ctrl.sv
// -----------------------------------------------------------------------------
// des_stream_ctrl
// Upstream feeder/collector for an iterative 16-round DES codec.
//  - Packs pairs of 32-bit input words into 64-bit blocks.
//    The first word becomes bits [63:32] and the second word becomes bits [31:0].
//  - Buffers the packed blocks in a small FIFO.
//  - Launches one codec operation at a time with a single-cycle start pulse.
//  - Keeps the codec key stable while the codec is computing.
//  - Returns the codec result on a 64-bit valid/ready output.
//
// Handshake rule for both streams:
//  - A transfer happens on a rising clock edge where valid && ready.
//  - The producer holds valid and data steady until that edge.
//  - ready may depend on internal state but never on the valid input.
//
// Ports
//  clk, rst       clock, synchronous active-high reset
//  s_valid/s_ready/s_data          32-bit input word stream
//  key_we/key_i                    key write strobe and value
//  m_valid/m_ready/m_data          64-bit result stream
//  des_valid_o/des_data_o/des_key_o  start pulse, block and key to the codec
//  des_valid_i/des_data_i          result strobe and block from the codec
//  blk_cnt                         completed-block counter (wraps)
//  err                             sticky codec timeout flag
//  dbg_state_o                     current FSM state (0 idle, 1 launch, 2 wait, 3 out)
// -----------------------------------------------------------------------------
module des_stream_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [31:0] s_data,
   input  logic        key_we,
   input  logic [63:0] key_i,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [63:0] m_data,
   output logic        des_valid_o,
   output logic [63:0] des_data_o,
   output logic [63:0] des_key_o,
   input  logic        des_valid_i,
   input  logic [63:0] des_data_i,
   output logic [15:0] blk_cnt,
   output logic        err,
   output logic [1:0]  dbg_state_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_OUT    = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [63:0] key_q, key_d;
   logic [63:0] pend_val_q, pend_val_d;
   logic        pend_q, pend_d;
   logic        m_valid_q, m_valid_d;
   logic [63:0] m_data_q, m_data_d;
   logic [15:0] blk_q, blk_d;
   logic        err_q, err_d;
   logic [63:0] des_data_q, des_data_d;

   // Word packer
   logic        half_q;
   logic [31:0] hold_q;

   // Block FIFO.
   // The pointers carry one extra wrap bit so that full and empty can be told apart.
   logic [63:0]   fifo_mem_q [FIFO_DEPTH];
   logic [AW:0]   wr_ptr_q, rd_ptr_q;
   logic          fifo_empty, fifo_full;
   logic [63:0]   fifo_head;
   logic          word_acc, push, pop;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign fifo_head  = fifo_mem_q[rd_ptr_q[AW-1:0]];

   // Every word stalls while the FIFO is full, including the first half of a block.
   assign s_ready  = !rst && !fifo_full;
   assign word_acc = s_valid && s_ready;
   assign push     = word_acc && half_q;
   // LAUNCH is only entered from IDLE with a non-empty FIFO, so this pop is always legal.
   assign pop      = (state_q == ST_LAUNCH);

   always_comb begin
      state_d    = state_q;
      tmo_d      = tmo_q;
      key_d      = key_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      m_valid_d  = m_valid_q;
      m_data_d   = m_data_q;
      blk_d      = blk_q;
      err_d      = err_q;
      des_data_d = des_data_q;

      // A key written while an operation is in flight is parked.
      // It is applied on the next visit to IDLE, and the latest write wins.
      if (key_we && (state_q != ST_IDLE)) begin
         pend_d     = 1'b1;
         pend_val_d = key_i;
      end

      case (state_q)
         ST_IDLE: begin
            // A key update costs one idle cycle.
            // This keeps des_key_o from changing on the edge that launches an operation.
            if (key_we) begin
               key_d  = key_i;
               pend_d = 1'b0;
            end else if (pend_q) begin
               key_d  = pend_val_q;
               pend_d = 1'b0;
            end else if (!fifo_empty) begin
               des_data_d = fifo_head;
               state_d    = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            tmo_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (des_valid_i) begin
               m_data_d  = des_data_i;
               m_valid_d = 1'b1;
               blk_d     = blk_q + 16'd1;
               state_d   = ST_OUT;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               // The popped block is dropped; the flag stays set until reset.
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_OUT: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         tmo_q      <= '0;
         key_q      <= '0;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         m_valid_q  <= 1'b0;
         m_data_q   <= '0;
         blk_q      <= '0;
         err_q      <= 1'b0;
         des_data_q <= '0;
         half_q     <= 1'b0;
         hold_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         tmo_q      <= tmo_d;
         key_q      <= key_d;
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
         m_valid_q  <= m_valid_d;
         m_data_q   <= m_data_d;
         blk_q      <= blk_d;
         err_q      <= err_d;
         des_data_q <= des_data_d;
         if (word_acc) begin
            half_q <= !half_q;
            if (!half_q) hold_q <= s_data;
         end
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage only; empty/full are defined by the pointers, so no reset is needed here.
   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= {hold_q, s_data};
   end

   assign des_valid_o = (state_q == ST_LAUNCH);
   assign des_data_o  = des_data_q;
   assign des_key_o   = key_q;
   assign m_valid     = m_valid_q;
   assign m_data      = m_data_q;
   assign blk_cnt     = blk_q;
   assign err         = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_des_stream_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for des_stream_ctrl.
//  - The codec is a stub that answers 17 cycles after each start pulse.
//  - The stub returns the known DES answer for the classic test vector.
//  - For any other block it returns a fixed scramble of the block and the key.
// -----------------------------------------------------------------------------
module tb_des_stream_ctrl;

   localparam int FIFO_DEPTH = 4;
   localparam int TIMEOUT    = 32;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [63:0] K1 = 64'h1334_5779_9BBC_DFF1;
   localparam logic [63:0] K2 = 64'hFEDC_BA98_7654_3210;

   logic        clk, rst;
   logic        s_valid, s_ready;
   logic [31:0] s_data;
   logic        key_we;
   logic [63:0] key_i;
   logic        m_valid, m_ready;
   logic [63:0] m_data;
   logic        des_valid_o, des_valid_i;
   logic [63:0] des_data_o, des_key_o, des_data_i;
   logic [15:0] blk_cnt;
   logic        err;
   logic [1:0]  dbg_state_o;

   des_stream_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .key_we(key_we), .key_i(key_i),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .des_valid_o(des_valid_o), .des_data_o(des_data_o), .des_key_o(des_key_o),
      .des_valid_i(des_valid_i), .des_data_i(des_data_i),
      .blk_cnt(blk_cnt), .err(err), .dbg_state_o(dbg_state_o)
   );

   // ---------------- clock / reset bookkeeping ----------------
   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int launch_cyc = 0;
   int n_launch   = 0;
   int rst_count  = 0;
   int n_exp_blk  = 0;
   logic stub_mute = 1'b0;
   logic m_valid_prev = 1'b0;
   logic [63:0] cur_key = 64'h0;
   logic [63:0] exp_q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] codec_model(input logic [63:0] d, input logic [63:0] k);
      if (d == 64'h0123_4567_89AB_CDEF && k == K1) return 64'h85E8_1354_0F0A_B405;
      return d ^ {k[31:0], k[63:32]} ^ 64'hA5A5_5A5A_0F0F_F0F0;
   endfunction

   // ---------------- codec stub ----------------
   initial begin : codec_stub
      logic [63:0] d, k;
      logic        key_moved;
      int          rst_snap;
      des_valid_i = 1'b0;
      des_data_i  = '0;
      forever begin
         @(negedge clk);
         if (des_valid_o && !rst) begin
            launch_cyc = cyc;
            n_launch++;
            d = des_data_o;
            k = des_key_o;
            key_moved = 1'b0;
            rst_snap  = rst_count;
            @(negedge clk);
            check("start_pulse_width", {63'b0, des_valid_o}, 64'd0);
            for (int i = 1; i < 17; i++) begin
               if (des_key_o !== k) key_moved = 1'b1;
               @(negedge clk);
            end
            if (!stub_mute) begin
               des_valid_i = 1'b1;
               des_data_i  = codec_model(d, k);
               @(negedge clk);
               des_valid_i = 1'b0;
            end
            if (rst_snap == rst_count) check("key_stable_in_op", {63'b0, key_moved}, 64'd0);
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (m_valid && !m_valid_prev)
         check("result_latency", 64'(cyc - launch_cyc), 64'd18);
      if (m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", m_data, 64'hxxxx_xxxx_xxxx_xxxx);
         end else begin
            check("m_data", m_data, exp_q.pop_front());
         end
      end
      m_valid_prev = m_valid;
   end

   // ---------------- driver tasks ----------------
   task automatic send_word(input logic [31:0] w);
      int n = 0;
      s_valid = 1'b1;
      s_data  = w;
      while (!s_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) check("s_ready_timeout", {63'b0, s_ready}, 64'd1);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic send_block(input logic [63:0] blk, input logic [63:0] k, input logic expect_it);
      send_word(blk[63:32]);
      send_word(blk[31:0]);
      if (expect_it) begin
         exp_q.push_back(codec_model(blk, k));
         n_exp_blk++;
      end
   endtask

   task automatic set_key(input logic [63:0] k);
      key_we = 1'b1;
      key_i  = k;
      @(negedge clk);
      key_we = 1'b0;
      cur_key = k;
   endtask

   task automatic wait_state(input logic [1:0] st, input int max_cyc, input string name);
      int n = 0;
      while (dbg_state_o != st && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check(name, {62'b0, dbg_state_o}, {62'b0, st});
   endtask

   task automatic wait_drain(input int max_cyc);
      int n = 0;
      while ((exp_q.size() != 0 || dbg_state_o != S_IDLE) && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      rst_count++;
      rst = 1'b1;
      @(negedge clk);
      check("rst_s_ready_low", {63'b0, s_ready}, 64'd0);
      rst = 1'b0;
      exp_q.delete();
      n_exp_blk = 0;
      cur_key   = 64'h0;
      @(negedge clk);
      check("rst_outputs", {m_valid, des_valid_o, err, blk_cnt, 2'(dbg_state_o)},
            {1'b0, 1'b0, 1'b0, 16'h0, S_IDLE});
      check("rst_m_data", m_data, 64'h0);
      check("rst_des_data", des_data_o, 64'h0);
      check("rst_des_key", des_key_o, 64'h0);
      check("rst_s_ready_high", {63'b0, s_ready}, 64'd1);
   endtask

   // ---------------- main stimulus ----------------
   initial begin
      int launches_before;
      rst = 1'b1; s_valid = 1'b0; s_data = '0; key_we = 1'b0; key_i = '0; m_ready = 1'b1;
      @(negedge clk);
      do_reset();

      // 1: classic DES vector through the encrypt codec
      set_key(K1);
      @(negedge clk);
      check("key_load_idle", des_key_o, K1);
      send_block(64'h0123_4567_89AB_CDEF, K1, 1'b1);
      wait_drain(100);

      // 3: key written during WAIT is deferred to the next block
      send_block(64'h0011_2233_4455_6677, K1, 1'b1);
      wait_state(S_WAIT, 20, "reach_wait");
      set_key(K2);
      repeat (3) @(negedge clk);
      check("key_held_in_wait", des_key_o, K1);
      send_block(64'h8899_AABB_CCDD_EEFF, K2, 1'b1);
      wait_drain(200);
      check("key_applied_in_idle", des_key_o, K2);

      // 2: overfill with the output stalled
      m_ready = 1'b0;
      for (int b = 0; b < FIFO_DEPTH + 1; b++)
         send_block({32'hB000_0000 + 32'(b), 32'h1234_0000 + 32'(b * 3)}, cur_key, 1'b1);
      check("fifo_full_stall", {63'b0, s_ready}, 64'd0);
      repeat (25) @(negedge clk);
      check("stall_hold", {63'b0, s_ready}, 64'd0);
      check("out_hold_valid", {63'b0, m_valid}, 64'd1);
      m_ready = 1'b1;
      send_block(64'hCAFE_F00D_DEAD_BEEF, cur_key, 1'b1);
      wait_drain(400);
      check("blk_cnt_after_burst", {48'b0, blk_cnt}, 64'(n_exp_blk));

      // 4: codec never answers -> timeout, then normal operation resumes
      stub_mute = 1'b1;
      send_block(64'h5555_AAAA_5555_AAAA, cur_key, 1'b0);
      begin
         int n = 0;
         while (!err && n < 80) begin
            @(negedge clk);
            n++;
         end
      end
      check("err_set", {63'b0, err}, 64'd1);
      check("err_latency", 64'(cyc - launch_cyc), 64'(TIMEOUT + 1));
      check("idle_after_timeout", {62'b0, dbg_state_o}, {62'b0, S_IDLE});
      check("blk_cnt_no_drop_count", {48'b0, blk_cnt}, 64'(n_exp_blk));
      stub_mute = 1'b0;
      send_block(64'h0F1E_2D3C_4B5A_6978, cur_key, 1'b1);
      wait_drain(100);
      check("err_sticky", {63'b0, err}, 64'd1);

      // 5a: reset in WAIT with another block queued
      send_block(64'h1111_1111_2222_2222, cur_key, 1'b1);
      send_block(64'h3333_3333_4444_4444, cur_key, 1'b1);
      wait_state(S_WAIT, 20, "reach_wait_before_rst");
      repeat (4) @(negedge clk);
      do_reset();
      launches_before = n_launch;
      repeat (30) @(negedge clk);
      check("no_late_result", {63'b0, m_valid}, 64'd0);
      check("fifo_empty_after_rst", 64'(n_launch), 64'(launches_before));

      // 5b: reset with a half-packed word
      send_word(32'hDEAD_0000);
      repeat (3) @(negedge clk);
      check("half_word_no_launch", {62'b0, dbg_state_o}, {62'b0, S_IDLE});
      do_reset();
      send_block(64'h1234_5678_9ABC_DEF0, 64'h0, 1'b1);
      wait_drain(100);
      check("blk_cnt_final", {48'b0, blk_cnt}, 64'd1);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
